// File: rtl/addsub_server.sv
// Shared bit-serial add/subtract responder for two requesters, round-robin arbitrated.
// Latency WIDTH+2 edges from grant to ready sampled; a request waits in IDLE until served.
module addsub_server #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_i,
   input  logic             mode0_i,
   input  logic [WIDTH-1:0] a0_bi,
   input  logic [WIDTH-1:0] b0_bi,
   output logic             ready0_o,
   input  logic             req1_i,
   input  logic             mode1_i,
   input  logic [WIDTH-1:0] a1_bi,
   input  logic [WIDTH-1:0] b1_bi,
   output logic             ready1_o,
   output logic [WIDTH-1:0] res_bo,
   output logic             busy_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2,
      COOL = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             grant_vld;
   logic             grant_idx;
   logic             last_grant;
   logic             gnt_q;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_nxt;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             sum_bit;
   logic             carry_nxt;
   logic             sel_mode;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_vld = 1'b0;
      grant_idx = last_grant;
      case (state)
         IDLE: begin
            if (req0_i || req1_i) begin
               grant_vld = 1'b1;
               // On a tie the port that did not win last time goes first
               grant_idx = (req0_i && req1_i) ? ~last_grant : req1_i;
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (cnt == LAST_STEP) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = COOL;
         COOL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign sel_mode  = grant_idx ? mode1_i : mode0_i;
   assign sel_a     = grant_idx ? a1_bi : a0_bi;
   assign sel_b     = grant_idx ? b1_bi : b0_bi;
   assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
   assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
   assign r_nxt     = {sum_bit, r_sr[WIDTH-1:1]};
   assign busy_o    = (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         a_sr       <= '0;
         b_sr       <= '0;
         r_sr       <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         gnt_q      <= 1'b0;
         last_grant <= 1'b1;
         res_bo     <= '0;
         ready0_o   <= 1'b0;
         ready1_o   <= 1'b0;
      end else if (grant_vld) begin
         // Subtract is a + ~b + 1: invert b and seed the carry
         a_sr       <= sel_a;
         b_sr       <= sel_mode ? sel_b : ~sel_b;
         carry      <= ~sel_mode;
         cnt        <= '0;
         gnt_q      <= grant_idx;
         last_grant <= grant_idx;
      end else if (state == CALC) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         r_sr  <= r_nxt;
         carry <= carry_nxt;
         cnt   <= cnt + CNT_W'(1);
         if (cnt == LAST_STEP) begin
            res_bo   <= r_nxt;
            ready0_o <= ~gnt_q;
            ready1_o <= gnt_q;
         end
      end else begin
         ready0_o <= 1'b0;
         ready1_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_addsub_server.sv
// Directed self-checking bench for addsub_server (WIDTH=8).
module tb_addsub_server;

   localparam int W = 8;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         req0_i = 1'b0;
   logic         mode0_i = 1'b0;
   logic [W-1:0] a0_bi = '0;
   logic [W-1:0] b0_bi = '0;
   logic         ready0_o;
   logic         req1_i = 1'b0;
   logic         mode1_i = 1'b0;
   logic [W-1:0] a1_bi = '0;
   logic [W-1:0] b1_bi = '0;
   logic         ready1_o;
   logic [W-1:0] res_bo;
   logic         busy_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ev_port [8];
   int ev_cyc  [8];
   int ev_res  [8];
   int n_ev;

   addsub_server #(.WIDTH(W)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req0_i   (req0_i),
      .mode0_i  (mode0_i),
      .a0_bi    (a0_bi),
      .b0_bi    (b0_bi),
      .ready0_o (ready0_o),
      .req1_i   (req1_i),
      .mode1_i  (mode1_i),
      .a1_bi    (a1_bi),
      .b1_bi    (b1_bi),
      .ready1_o (ready1_o),
      .res_bo   (res_bo),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input bit port, input bit req, input bit mode,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      if (port) begin
         req1_i = req; mode1_i = mode; a1_bi = a; b1_bi = b;
      end else begin
         req0_i = req; mode0_i = mode; a0_bi = a; b0_bi = b;
      end
   endtask

   // One request on one port. hold = negedges after the ready sample before req drops.
   // lat = edges from the grant edge (counted as 1) to the edge that samples ready.
   task automatic run_op(input string tag, input bit port, input bit mode,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int hold, input bit perturb);
      int edges, pulses, other, lat, drop_at;
      logic [W-1:0] got;
      @(negedge clk_i);
      drive(port, 1'b1, mode, a, b);
      edges = 0; pulses = 0; other = 0; lat = 0; drop_at = -1; got = '0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk_i);
         edges++;
         @(negedge clk_i);
         if (perturb && edges == 3) begin
            drive(port, 1'b1, ~mode, ~a, b);
         end
         if (port ? ready0_o : ready1_o) other++;
         if (port ? ready1_o : ready0_o) begin
            pulses++;
            if (pulses == 1) begin
               lat = edges + 1;
               got = res_bo;
               drop_at = edges + hold;
            end
         end
         if (edges == drop_at) drive(port, 1'b0, mode, a, b);
      end
      drive(port, 1'b0, mode, a, b);
      chk({tag, "_res"}, 32'(got), 32'(exp));
      chk({tag, "_pulses"}, pulses, 1);
      chk({tag, "_latency"}, lat, W + 2);
      chk({tag, "_other_ready"}, other, 0);
      chk({tag, "_res_hold"}, 32'(res_bo), 32'(exp));
      chk({tag, "_idle"}, 32'(busy_o), 0);
   endtask

   // Both ports requesting together; each drops req one negedge after its ready sample.
   task automatic tie_round(input string tag);
      bit pend0, pend1;
      pend0 = 1'b0; pend1 = 1'b0; n_ev = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i);
         cyc++;
         @(negedge clk_i);
         if (pend0) begin req0_i = 1'b0; pend0 = 1'b0; end
         if (pend1) begin req1_i = 1'b0; pend1 = 1'b0; end
         if (ready0_o && ready1_o) chk({tag, "_both_ready"}, 1, 0);
         if (n_ev < 8 && (ready0_o || ready1_o)) begin
            ev_port[n_ev] = ready1_o ? 1 : 0;
            ev_cyc[n_ev]  = cyc;
            ev_res[n_ev]  = int'(res_bo);
            n_ev++;
            if (ready0_o) pend0 = 1'b1;
            if (ready1_o) pend1 = 1'b1;
         end
      end
      req0_i = 1'b0; req1_i = 1'b0;
      chk({tag, "_events"}, n_ev, 2);
      if (n_ev >= 2) begin
         chk({tag, "_first_port"}, ev_port[0], 0);
         chk({tag, "_first_res"}, ev_res[0], 2);
         chk({tag, "_second_port"}, ev_port[1], 1);
         chk({tag, "_second_res"}, ev_res[1], 5);
         chk({tag, "_period"}, ev_cyc[1] - ev_cyc[0], W + 3);
      end
   endtask

   initial begin
      int stray;
      // Reset values
      #12;
      chk("rst_ready0", 32'(ready0_o), 0);
      chk("rst_ready1", 32'(ready1_o), 0);
      chk("rst_res", 32'(res_bo), 0);
      chk("rst_busy", 32'(busy_o), 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("idle_busy", 32'(busy_o), 0);

      run_op("add_p0", 1'b0, 1'b1, 8'd100, 8'd27, 8'd127, 1, 1'b0);
      run_op("sub_3_5", 1'b1, 1'b0, 8'd3, 8'd5, 8'd254, 1, 1'b0);
      run_op("add_250_10", 1'b1, 1'b1, 8'd250, 8'd10, 8'd4, 1, 1'b0);
      run_op("sub_0_0", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1, 1'b0);
      run_op("hold_p0", 1'b0, 1'b0, 8'd200, 8'd55, 8'd145, 1, 1'b1);
      run_op("late_drop", 1'b0, 1'b1, 8'd17, 8'd18, 8'd35, 2, 1'b0);

      // Tie from reset, then a second tie to show alternation continues 0,1
      @(negedge clk_i);
      rst_i = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 8'd1, 8'd1);
      drive(1'b1, 1'b1, 1'b0, 8'd9, 8'd4);
      @(negedge clk_i);
      rst_i = 1'b1;
      tie_round("tie1");
      @(negedge clk_i);
      drive(1'b0, 1'b1, 1'b1, 8'd1, 8'd1);
      drive(1'b1, 1'b1, 1'b0, 8'd9, 8'd4);
      tie_round("tie2");

      // Reset mid-CALC at step 4
      @(negedge clk_i);
      drive(1'b0, 1'b1, 1'b1, 8'd60, 8'd6);
      @(posedge clk_i);
      repeat (4) @(posedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      chk("mid_rst_ready0", 32'(ready0_o), 0);
      chk("mid_rst_ready1", 32'(ready1_o), 0);
      chk("mid_rst_res", 32'(res_bo), 0);
      chk("mid_rst_busy", 32'(busy_o), 0);
      drive(1'b0, 1'b0, 1'b1, 8'd60, 8'd6);
      @(negedge clk_i);
      rst_i = 1'b1;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (ready0_o || ready1_o || busy_o) stray++;
      end
      chk("mid_rst_no_ready", stray, 0);
      run_op("after_rst", 1'b0, 1'b0, 8'd60, 8'd6, 8'd54, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
